// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
// FSM state encoding, default counter width and timeout.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int          CNT_W_DEF   = 28;
  localparam logic [27:0] TIMEOUT_DEF = 28'd1000000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer plus rising-edge detector.
// Ports: clock_in, reset_n (sync, active-low), sig_in -> s_lvl, rise.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sig_in,
  output logic s_lvl,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              s_prev;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], sig_in};
      s_prev <= sync[STAGES-1];
    end
  end

  assign s_lvl = sync[STAGES-1];
  assign rise  = s_lvl & ~s_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period/high time of an async input, tracks lock and loss.
// Ports: clock_in, reset_n, sig_in, clear -> period_out, high_out,
//   meas_valid, locked, lost, err_cnt; duty_err with DUTY_CHECK_EN.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter int               TOL         = 1,
  parameter int               LOCK_COUNT  = 4,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_cnt
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);

  logic             s_lvl;
  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] prev_period;
  logic [CNT_W-1:0] diff;
  logic [3:0]       match_cnt;
  logic [3:0]       match_nxt;
  logic             match;
  logic             timeout;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .sig_in   (sig_in),
    .s_lvl    (s_lvl),
    .rise     (rise)
  );

  // max - min keeps the difference unsigned without wrap
  always_comb begin
    diff = (per_cnt >= prev_period) ?
           per_cnt - prev_period :
           prev_period - per_cnt;
    match     = diff <= TOL_C;
    match_nxt = match_cnt + 4'd1;
    timeout   = (state != IDLE) &&
                (per_cnt >= TIMEOUT) && !rise;
  end

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W:0] DUTY_TOL = (CNT_W+1)'(2*TOL);
  logic [CNT_W:0] two_hi;
  logic [CNT_W:0] per_x;
  logic [CNT_W:0] duty_diff;

  always_comb begin
    two_hi    = {hi_cnt, 1'b0};
    per_x     = {1'b0, per_cnt};
    duty_diff = (two_hi >= per_x) ?
                two_hi - per_x : per_x - two_hi;
  end
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + CNT_W'(1);
      if (s_lvl && hi_cnt != CNT_MAX)
        hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state       <= IDLE;
      period_out  <= '0;
      high_out    <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
      err_cnt     <= 8'd0;
      match_cnt   <= 4'd0;
      prev_period <= '0;
`ifdef DUTY_CHECK_EN
      duty_err    <= 1'b0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (clear) begin
        lost    <= 1'b0;
        err_cnt <= 8'd0;
      end
      // a rise always wins over a coincident timeout
      if (rise) begin
        if (state != IDLE) begin
          period_out  <= per_cnt;
          high_out    <= hi_cnt;
          meas_valid  <= 1'b1;
          prev_period <= per_cnt;
`ifdef DUTY_CHECK_EN
          duty_err    <= duty_diff > DUTY_TOL;
`endif
        end
        unique case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            state     <= TRACK;
            match_cnt <= 4'd0;
          end
          TRACK: begin
            if (match) begin
              match_cnt <= match_nxt;
              if (match_nxt == LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (!match) begin
              state     <= TRACK;
              locked    <= 1'b0;
              match_cnt <= 4'd0;
              if (!clear && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state     <= IDLE;
        locked    <= 1'b0;
        lost      <= 1'b1;
        match_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed scoreboard bench for clk_period_meter.
// Two instances: TOL=1 (main) and TOL=0 (no-lock check), TIMEOUT=50.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig = 1'b0;
  logic        clr = 1'b0;

  logic [27:0] per_a, hi_a, per_b, hi_b;
  logic        mv_a, lk_a, lost_a;
  logic        mv_b, lk_b, lost_b;
  logic [7:0]  err_a, err_b;
`ifdef DUTY_CHECK_EN
  logic        duty_a, duty_b;
`endif

  always #5 clk = ~clk;

  clk_period_meter #(
    .TOL     (1),
    .TIMEOUT (28'd50)
  ) dut_a (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .sig_in     (sig),
    .clear      (clr),
    .period_out (per_a),
    .high_out   (hi_a),
    .meas_valid (mv_a),
    .locked     (lk_a),
    .lost       (lost_a),
    .err_cnt    (err_a)
`ifdef DUTY_CHECK_EN
    ,
    .duty_err   (duty_a)
`endif
  );

  clk_period_meter #(
    .TOL     (0),
    .TIMEOUT (28'd50)
  ) dut_b (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .sig_in     (sig),
    .clear      (clr),
    .period_out (per_b),
    .high_out   (hi_b),
    .meas_valid (mv_b),
    .locked     (lk_b),
    .lost       (lost_b),
    .err_cnt    (err_b)
`ifdef DUTY_CHECK_EN
    ,
    .duty_err   (duty_b)
`endif
  );

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_mv = 0;
  bit   b_lk_seen = 1'b0;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic bit duty_of(int p, int h);
    int d;
    d = (2*h > p) ? 2*h - p : p - 2*h;
    return d > 2;
  endfunction

  // one input period: high for h cycles, low for n-h;
  // optionally queue the measurement this rise should report
  task automatic pulse(int n, int h, bit push,
                       int ep, int eh, bit el);
    exp_t e;
    if (push) begin
      e.p = ep;
      e.h = eh;
      e.lk = el;
      q.push_back(e);
    end
    sig = 1'b1;
    repeat (h) @(negedge clk);
    sig = 1'b0;
    repeat (n - h) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_period"}, 32'(per_a), 0);
    chk({tag, "_high"}, 32'(hi_a), 0);
    chk({tag, "_mv"}, 32'(mv_a), 0);
    chk({tag, "_locked"}, 32'(lk_a), 0);
    chk({tag, "_lost"}, 32'(lost_a), 0);
    chk({tag, "_err"}, 32'(err_a), 0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lk_b) b_lk_seen = 1'b1;
    if (mv_a) begin
      last_mv = cyc;
      if (q.size() == 0) begin
        chk("unexpected_meas", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("period", 32'(per_a), mon_e.p);
        chk("high", 32'(hi_a), mon_e.h);
        chk("locked", 32'(lk_a), 32'(mon_e.lk));
`ifdef DUTY_CHECK_EN
        chk("duty", 32'(duty_a),
            32'(duty_of(mon_e.p, mon_e.h)));
`endif
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // divide-by-4, 50% duty: lock on the sixth rise
    pulse(4, 2, 0, 0, 0, 0);
    for (int k = 2; k <= 7; k++)
      pulse(4, 2, 1, 4, 2, k >= 6);
    chk("lock_p4", 32'(lk_a), 1);

    // switch to period 7: drop, count error, relock
    pulse(7, 3, 1, 4, 2, 1);
    pulse(7, 3, 1, 7, 3, 0);
    chk("err_after_drop", 32'(err_a), 1);
    repeat (3) pulse(7, 3, 1, 7, 3, 0);
    pulse(7, 3, 1, 7, 3, 1);
    pulse(7, 3, 1, 7, 3, 1);
    chk("err_after_relock", 32'(err_a), 1);
    chk("drain_b", q.size(), 0);

    // input stopped low: timeout 50 cycles after last rise
    for (int i = 0; i < 200 && !lost_a; i++)
      @(negedge clk);
    chk("timeout_lost", 32'(lost_a), 1);
    chk("timeout_cycles", cyc - last_mv, 50);
    chk("timeout_unlock", 32'(lk_a), 0);
    chk("timeout_err_kept", 32'(err_a), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear_lost", 32'(lost_a), 0);
    chk("clear_err", 32'(err_a), 0);

    // relock, then reset mid-period
    pulse(4, 2, 0, 0, 0, 0);
    for (int k = 2; k <= 7; k++)
      pulse(4, 2, 1, 4, 2, k >= 6);
    repeat (2) @(negedge clk);
    chk("locked_pre_reset", 32'(lk_a), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    pulse(4, 2, 0, 0, 0, 0);
    pulse(4, 2, 1, 4, 2, 0);
    chk("drain_d", q.size(), 0);

    // 5/6 alternating: TOL=1 locks, TOL=0 never does
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_lk_seen = 1'b0;
    pulse(5, 2, 0, 0, 0, 0);
    pulse(6, 2, 1, 5, 2, 0);
    pulse(5, 2, 1, 6, 2, 0);
    pulse(6, 2, 1, 5, 2, 0);
    pulse(5, 2, 1, 6, 2, 0);
    pulse(6, 2, 1, 5, 2, 1);
    pulse(5, 2, 1, 6, 2, 1);
    pulse(6, 2, 1, 5, 2, 1);
    chk("alt_lock_tol1", 32'(lk_a), 1);
    chk("alt_nolock_tol0", 32'(b_lk_seen), 0);
    chk("alt_err_tol0", 32'(err_b), 0);
    chk("drain_e", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
